// File: rtl/pc_sequencer_pkg.sv
// pc_sequencer_pkg: shared FSM state encodings and default sizing for the fetch PC sequencer
package pc_sequencer_pkg;
  typedef enum logic [1:0] {RUN = 2'd0, FLUSH = 2'd1, HALT = 2'd2, UNUSED = 2'd3} state_t;
  localparam int PC_W_DEF = 4;
  localparam int FLUSH_CYCLES_DEF = 2;
endpackage

// File: rtl/pc_flush_counter.sv
// pc_flush_counter: loads CYCLES-1 on a taken branch, counts down while flushing, flags zero
module pc_flush_counter #(
  parameter int CYCLES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic dec,
  output logic zero
);
  localparam int W = $clog2(CYCLES) + 1;
  logic [W-1:0] cnt;
  always_ff @(posedge clk or posedge reset)
    if (reset) cnt <= '0;
    else if (load) cnt <= W'(CYCLES - 1);
    else if (dec && cnt != '0) cnt <= cnt - 1'b1;
  assign zero = cnt == '0;
endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: fetch PC register with branch flush, stall and halt control; PC_SEQ_BRANCH_CNT_EN adds branch_cnt_out
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter int PC_W = PC_W_DEF,
  parameter int FLUSH_CYCLES = FLUSH_CYCLES_DEF
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall_in,
  input  logic            branch_taken,
  input  logic [PC_W-1:0] branch_target,
  input  logic            halt_in,
  input  logic            resume_in,
  output logic [PC_W-1:0] pc_out,
  output logic [PC_W-1:0] pc_plus1_out,
  output logic            sel_jmp_out,
  output logic            flush_out,
  output logic            pc_we_out,
`ifdef PC_SEQ_BRANCH_CNT_EN
  output logic [7:0]      branch_cnt_out,
`endif
  output logic [1:0]      state_out
);
  state_t state, state_nxt;
  logic run, flushing, zero;
  assign run = state == RUN;
  assign flushing = state == FLUSH;
  assign sel_jmp_out = run & branch_taken;
  assign pc_we_out = sel_jmp_out | flushing | (run & ~halt_in & ~stall_in);
  assign pc_plus1_out = pc_out + 1'b1;
  assign state_out = state;
  always_comb begin
    state_nxt = RUN;
    if (run) state_nxt = branch_taken ? FLUSH : halt_in ? HALT : RUN;
    else if (flushing) state_nxt = zero ? RUN : FLUSH;
    else if (state == HALT) state_nxt = resume_in ? RUN : HALT;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      pc_out <= '0;
      state <= RUN;
      flush_out <= 1'b0;
    end else begin
      pc_out <= pc_we_out ? (sel_jmp_out ? branch_target : pc_plus1_out) : pc_out;
      state <= state_nxt;
      flush_out <= state_nxt == FLUSH;
    end
  pc_flush_counter #(.CYCLES(FLUSH_CYCLES)) u_flush_cnt (
    .clk(clk),
    .reset(reset),
    .load(sel_jmp_out),
    .dec(flushing),
    .zero(zero)
  );
`ifdef PC_SEQ_BRANCH_CNT_EN
  always_ff @(posedge clk or posedge reset)
    if (reset) branch_cnt_out <= '0;
    else if (sel_jmp_out && branch_cnt_out != 8'hFF) branch_cnt_out <= branch_cnt_out + 1'b1;
`endif
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: randomized and directed scoreboard bench for pc_sequencer against a behavioural model
module tb_pc_sequencer;
  typedef struct {
    logic [3:0] pc;
    logic [3:0] p1;
    logic       sel;
    logic       we;
    logic       fl;
    logic [1:0] st;
    logic [7:0] bc;
  } exp_t;
  logic clk = 0, reset = 1, stall_in = 0, branch_taken = 0, halt_in = 0, resume_in = 0;
  logic [3:0] branch_target = 0, pc_out, pc_plus1_out;
  logic sel_jmp_out, flush_out, pc_we_out;
  logic [1:0] state_out;
`ifdef PC_SEQ_BRANCH_CNT_EN
  logic [7:0] branch_cnt_out;
`endif
  int vectors = 0, miscompares = 0;
  int m_pc = 0, m_mode = 0, m_left = 0, m_bc = 0;
  exp_t q[$];
  exp_t mon_e;
  pc_sequencer #(.PC_W(4), .FLUSH_CYCLES(2)) dut (
    .clk(clk),
    .reset(reset),
    .stall_in(stall_in),
    .branch_taken(branch_taken),
    .branch_target(branch_target),
    .halt_in(halt_in),
    .resume_in(resume_in),
    .pc_out(pc_out),
    .pc_plus1_out(pc_plus1_out),
    .sel_jmp_out(sel_jmp_out),
    .flush_out(flush_out),
    .pc_we_out(pc_we_out),
`ifdef PC_SEQ_BRANCH_CNT_EN
    .branch_cnt_out(branch_cnt_out),
`endif
    .state_out(state_out)
  );
  always #5 clk = ~clk;
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] x);
    vectors++;
    if (a !== x) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, a, x, $time);
    end
  endtask
  always @(negedge clk)
    if (q.size() > 0) begin
      mon_e = q.pop_front();
      chk("pc_out", 32'(pc_out), 32'(mon_e.pc));
      chk("pc_plus1_out", 32'(pc_plus1_out), 32'(mon_e.p1));
      chk("sel_jmp_out", 32'(sel_jmp_out), 32'(mon_e.sel));
      chk("pc_we_out", 32'(pc_we_out), 32'(mon_e.we));
      chk("flush_out", 32'(flush_out), 32'(mon_e.fl));
      chk("state_out", 32'(state_out), 32'(mon_e.st));
`ifdef PC_SEQ_BRANCH_CNT_EN
      chk("branch_cnt_out", 32'(branch_cnt_out), 32'(mon_e.bc));
`endif
    end
  // Expected outputs for the current cycle, from the model's view of mode and PC.
  task automatic push_exp(input logic bt, input logic h, input logic s);
    exp_t e;
    e.sel = m_mode == 0 && bt;
    e.we = e.sel || m_mode == 1 || (m_mode == 0 && !h && !s);
    e.pc = 4'(m_pc);
    e.p1 = 4'((m_pc + 1) % 16);
    e.fl = m_mode == 1;
    e.st = 2'(m_mode);
    e.bc = 8'(m_bc);
    q.push_back(e);
  endtask
  task automatic step(input logic bt, input logic [3:0] tgt, input logic h, input logic s, input logic r);
    @(posedge clk);
    #1;
    reset = 0;
    branch_taken = bt;
    branch_target = tgt;
    halt_in = h;
    stall_in = s;
    resume_in = r;
    push_exp(bt, h, s);
    if (m_mode == 0) begin
      if (bt) begin
        m_pc = tgt;
        m_mode = 1;
        m_left = 2;
        if (m_bc < 255) m_bc++;
      end else if (h) m_mode = 2;
      else if (!s) m_pc = (m_pc + 1) % 16;
    end else if (m_mode == 1) begin
      m_pc = (m_pc + 1) % 16;
      m_left--;
      if (m_left == 0) m_mode = 0;
    end else if (r) m_mode = 0;
  endtask
  task automatic do_reset();
    @(posedge clk);
    #1;
    reset = 1;
    {branch_taken, halt_in, stall_in, resume_in} = '0;
    m_pc = 0;
    m_mode = 0;
    m_left = 0;
    m_bc = 0;
    push_exp(0, 0, 0);
  endtask
  task automatic free_until(input int pc);
    for (int i = 0; i < 20 && !(m_pc == pc && m_mode == 0); i++) step(0, 0, 0, 0, 0);
  endtask
  initial begin
    do_reset();
    repeat (5) step(0, 0, 0, 0, 0);
    free_until(14);
    repeat (3) step(0, 0, 0, 0, 0);
    free_until(3);
    step(1, 4'hA, 0, 1, 0);
    step(1, 4'h5, 0, 0, 0);
    step(1, 4'h7, 1, 1, 0);
    repeat (2) step(0, 0, 0, 0, 0);
    free_until(6);
    repeat (3) step(0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0);
    free_until(5);
    step(0, 0, 1, 0, 0);
    repeat (10) step(1'($urandom), 4'($urandom), 0, 1'($urandom), 0);
    step(0, 0, 0, 0, 1);
    repeat (2) step(0, 0, 0, 0, 1);
    repeat (3) begin
      step(1, 4'h9, 0, 0, 0);
      repeat (2) step(0, 0, 0, 0, 0);
    end
    step(1, 4'h2, 0, 0, 0);
    do_reset();
    repeat (3) step(0, 0, 0, 0, 0);
    repeat (900) step(1, 4'($urandom), 0, 0, 0);
    for (int i = 0; i < 3000; i++)
      if ($urandom_range(99) == 0) do_reset();
      else step($urandom_range(3) == 0, 4'($urandom), $urandom_range(7) == 0,
                $urandom_range(3) == 0, $urandom_range(2) == 0);
    repeat (2) @(negedge clk);
    if (q.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
